aes_sub_bytes_iter: RTL

AES_SUB_BYTES_ITER -- requirements
Module: aes_sub_bytes_iter

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_sbox_dual.sv | 83 ++++++++
 rtl/aes_sub_bytes_iter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared declarations for the iterative AES SubBytes block:
//   aes_state_e      - controller states IDLE / BUSY / DONE
//   AES_BLOCK_BYTES  - bytes in one AES state (16)
//   aes_lanes_legal  - returns 1 when a LANES value divides the state evenly
//                      and is one of 1, 2, 4, 8, 16
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  localparam int AES_BLOCK_BYTES = 16;

  function automatic bit aes_lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
           (lanes == 8) || (lanes == 16);
  endfunction

endpackage

// File: rtl/aes_sbox_dual.sv
// ---------------------------------------------------------------------------
// aes_sbox_dual
// One-byte combinational AES S-box / inverse S-box, computed arithmetically
// (GF(2^8) inversion plus the affine map) rather than from a stored table.
// Ports:
//   in_byte  [7:0] - byte to substitute
//   inverse        - 1 = inverse S-box, 0 = forward S-box
//   out_byte [7:0] - substituted byte
// Macro AES_SUB_BYTES_FWD_EN: when defined both directions are built and
// 'inverse' selects; otherwise only the inverse path exists.
// ---------------------------------------------------------------------------
module aes_sbox_dual (
  input  logic [7:0] in_byte,
  input  logic       inverse,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] base;
    logic [7:0] r;
    base = x;
    r    = 8'h01;
    for (int i = 1; i < 8; i++) begin
      base = gf_mul(base, base);
      r    = gf_mul(r, base);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] s);
    return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
  endfunction

`ifdef AES_SUB_BYTES_FWD_EN
  function automatic logic [7:0] affine_fwd(input logic [7:0] x);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  logic [7:0] fwd_s;
  logic [7:0] inv_s;

  // Both directions are evaluated; the mode bit picks one.
  always_comb begin
    fwd_s = affine_fwd(gf_inv(in_byte));
    inv_s = gf_inv(affine_inv(in_byte));
    if (inverse) begin
      out_byte = inv_s;
    end else begin
      out_byte = fwd_s;
    end
  end
`else
  logic unused_inverse_s;
  assign unused_inverse_s = inverse;

  // Inverse-only build: the mode input has no effect.
  always_comb begin
    out_byte = gf_inv(affine_inv(in_byte));
  end
`endif

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// ---------------------------------------------------------------------------
// aes_sub_bytes_iter
// Iterative AES SubBytes / InvSubBytes over a 128-bit state, LANES bytes per
// cycle. A block is accepted in IDLE, processed in 16/LANES BUSY cycles and
// held in DONE until the consumer takes it.
// Parameter: LANES (1, 2, 4, 8, 16) - bytes substituted per cycle.
// Ports:
//   Clk, Rst (synchronous, active-high)
//   In_valid / In_ready / In_block[127:0] / In_inverse - input handshake
//   Out_valid / Out_ready / Out_block[127:0]            - output handshake
// Byte i of a block occupies bits [127-8i : 120-8i].
// Macro AES_SUB_BYTES_FWD_EN: enables the forward S-box; without it every
// block is inverse-substituted and In_inverse is ignored.
// ---------------------------------------------------------------------------
module aes_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         In_valid,
  output logic         In_ready,
  input  logic [127:0] In_block,
  input  logic         In_inverse,
  output logic         Out_valid,
  input  logic         Out_ready,
  output logic [127:0] Out_block
);

  if (!aes_lanes_legal(LANES)) begin : g_bad_lanes
    $error("aes_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int GROUPS = AES_BLOCK_BYTES / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] LAST_GROUP = CW'(GROUPS - 1);

  aes_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mode_q, mode_d;
  logic [127:0]   work_q, work_d;
  logic           out_valid_q, out_valid_d;
  logic [127:0]   out_block_q, out_block_d;

  logic [7:0]     sb_in_s  [LANES];
  logic [7:0]     sb_out_s [LANES];
  logic           mode_in_s;

`ifdef AES_SUB_BYTES_FWD_EN
  assign mode_in_s = In_inverse;
`else
  logic unused_in_inverse_s;
  assign unused_in_inverse_s = In_inverse;
  assign mode_in_s = 1'b1;
`endif

  // LSB position of byte (c*LANES + l); byte 0 sits at the top of the word.
  function automatic logic [6:0] lane_lsb(input logic [CW-1:0] c, input int l);
    return 7'(8 * (AES_BLOCK_BYTES - 1 - (int'(c) * LANES + l)));
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign sb_in_s[l] = work_q[lane_lsb(cnt_q, l) +: 8];
    aes_sbox_dual u_sbox (
      .in_byte  (sb_in_s[l]),
      .inverse  (mode_q),
      .out_byte (sb_out_s[l])
    );
  end

  assign In_ready  = (state_q == IDLE) && !Rst;
  assign Out_valid = out_valid_q;
  assign Out_block = out_block_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    work_d      = work_q;
    out_valid_d = out_valid_q;
    out_block_d = out_block_q;
    case (state_q)
      IDLE: begin
        if (In_valid && In_ready) begin
          state_d = BUSY;
          work_d  = In_block;
          mode_d  = mode_in_s;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[lane_lsb(cnt_q, l) +: 8] = sb_out_s[l];
        end
        if (cnt_q == LAST_GROUP) begin
          cnt_d       = {CW{1'b0}};
          state_d     = DONE;
          out_valid_d = 1'b1;
          // Publish the fully substituted word as it enters the working register.
          out_block_d = work_d;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = BUSY;
        end
      end
      DONE: begin
        if (Out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_block_d = 128'd0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = {CW{1'b0}};
        out_valid_d = 1'b0;
        out_block_d = 128'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      mode_q      <= 1'b0;
      work_q      <= 128'd0;
      out_valid_q <= 1'b0;
      out_block_q <= 128'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      work_q      <= work_d;
      out_valid_q <= out_valid_d;
      out_block_q <= out_block_d;
    end
  end

endmodule
